alu: RTL and testbench



---
 rtl/alu.sv | 129 ++++++++++++
 tb/tb_alu.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu.sv
// alu -- parameterized N-bit arithmetic/logic unit with a single output
// register stage. Every rising clock edge captures one operation; the
// result and its status flags are visible for the whole following cycle.
//
// Ports:
//   clk    system clock, rising-edge active
//   rst_n  asynchronous active-low reset; clears out and all flags
//   A      operand A (N bits)
//   B      operand B (N bits); also the unsigned shift amount
//   sel    operation select:
//            0000 ADD  0001 SUB  0010 AND  0011 OR   0100 XOR
//            0101 SLL  0110 SRL  0111 SRA  1000 NOT  1001 PASS
//            1010-1111 reserved (result 0, no carry, no overflow)
//   out    registered result (N bits)
//   Z      registered zero flag      (result == 0)
//   O      registered signed overflow (ADD/SUB only)
//   Ca     registered carry / last shifted-out bit
//   Neg    registered negative flag  (result MSB)
module alu #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [3:0]   sel,
   output logic [N-1:0] out,
   output logic         Z,
   output logic         O,
   output logic         Ca,
   output logic         Neg
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_NOT  = 4'b1000;
   localparam logic [3:0] OP_PASS = 4'b1001;

   localparam logic [N:0] ONE_W = (N+1)'(1);

   // All shift/arith intermediates are N+1 bits wide so the extra bit
   // carries the carry-out (arith, SLL) or the last bit shifted out of
   // the LSB end (SRL, SRA).
   logic [N:0]        add_full;
   logic [N:0]        sub_full;
   logic [N:0]        sll_full;
   logic [N:0]        srl_full;
   logic signed [N:0] sra_full;

   logic [N-1:0] res;
   logic         res_ca;
   logic         res_ov;

   always_comb begin
      add_full = {1'b0, A} + {1'b0, B};
      // Subtraction as A + ~B + 1: the carry out is the "no borrow" bit.
      sub_full = {1'b0, A} + {1'b0, ~B} + ONE_W;
      // {0,A} << B: bit N is A[N-B] for 1<=B<=N, zero for B=0 or B>N.
      sll_full = {1'b0, A} << B;
      // {A,0} >> B: bit 0 is A[B-1] for 1<=B<=N, zero for B=0 or B>N.
      srl_full = {A, 1'b0} >> B;
      // Arithmetic variant: for B>N every bit, including the carry slot,
      // becomes A[N-1].
      sra_full = $signed({A, 1'b0}) >>> B;
   end

   always_comb begin
      res    = '0;
      res_ca = 1'b0;
      res_ov = 1'b0;
      case (sel)
         OP_ADD: begin
            res    = add_full[N-1:0];
            res_ca = add_full[N];
            res_ov = (A[N-1] == B[N-1]) && (add_full[N-1] != A[N-1]);
         end
         OP_SUB: begin
            res    = sub_full[N-1:0];
            res_ca = sub_full[N];
            res_ov = (A[N-1] != B[N-1]) && (sub_full[N-1] != A[N-1]);
         end
         OP_AND:  res = A & B;
         OP_OR:   res = A | B;
         OP_XOR:  res = A ^ B;
         OP_SLL: begin
            res    = sll_full[N-1:0];
            res_ca = sll_full[N];
         end
         OP_SRL: begin
            res    = srl_full[N:1];
            res_ca = srl_full[0];
         end
         OP_SRA: begin
            res    = sra_full[N:1];
            res_ca = sra_full[0];
         end
         OP_NOT:  res = ~A;
         OP_PASS: res = B;
         default: begin
            res    = '0;
            res_ca = 1'b0;
            res_ov = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= '0;
         Z   <= 1'b0;
         O   <= 1'b0;
         Ca  <= 1'b0;
         Neg <= 1'b0;
      end else begin
         out <= res;
         Z   <= (res == '0);
         O   <= res_ov;
         Ca  <= res_ca;
         Neg <= res[N-1];
      end
   end

endmodule

// File: tb/tb_alu.sv
// tb_alu -- directed, table-driven bench for alu at N = 4. Vectors are
// applied on consecutive clock edges (so back-to-back throughput and the
// one-cycle latency are exercised), followed by hand-written reset and
// input-stability sequences.
module tb_alu;

   localparam int N = 4;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic [3:0]   sel;
   logic [N-1:0] out;
   logic         Z, O, Ca, Neg;

   int applied;
   int miscompares;

   typedef struct {
      logic [3:0]   sel;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] out;
      logic         z;
      logic         o;
      logic         ca;
      logic         neg;
   } vec_t;

   localparam int NV = 26;
   vec_t vecs[NV];

   alu #(.N(N)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .A    (A),
      .B    (B),
      .sel  (sel),
      .out  (out),
      .Z    (Z),
      .O    (O),
      .Ca   (Ca),
      .Neg  (Neg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [N-1:0] e_out,
                        input logic e_z, input logic e_o, input logic e_ca,
                        input logic e_neg);
      applied++;
      if (out !== e_out || Z !== e_z || O !== e_o || Ca !== e_ca || Neg !== e_neg) begin
         miscompares++;
         $display("FAIL %s: got out=%b Z=%b O=%b Ca=%b Neg=%b, want out=%b Z=%b O=%b Ca=%b Neg=%b",
                  name, out, Z, O, Ca, Neg, e_out, e_z, e_o, e_ca, e_neg);
      end
   endtask

   initial begin
      applied     = 0;
      miscompares = 0;

      //               sel      A        B        out      z     o     ca    neg
      vecs[0]  = '{4'b0000, 4'b0011, 4'b1101, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0}; // ADD wrap to 0
      vecs[1]  = '{4'b0000, 4'b0111, 4'b0010, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b1}; // ADD overflow
      vecs[2]  = '{4'b0001, 4'b0111, 4'b1101, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b1}; // SUB overflow, borrow
      vecs[3]  = '{4'b0001, 4'b1111, 4'b0110, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b1}; // SUB no borrow
      vecs[4]  = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1}; // AND
      vecs[5]  = '{4'b0010, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0}; // AND zero
      vecs[6]  = '{4'b0011, 4'b1011, 4'b0010, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b1}; // OR
      vecs[7]  = '{4'b0100, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0}; // XOR
      vecs[8]  = '{4'b0101, 4'b1001, 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0}; // SLL 1
      vecs[9]  = '{4'b0111, 4'b1000, 4'b0101, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b1}; // SRA B>N
      vecs[10] = '{4'b0110, 4'b1000, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0}; // SRL B=N
      vecs[11] = '{4'b0110, 4'b1000, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0}; // SRL B>N
      vecs[12] = '{4'b0101, 4'b0001, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0}; // SLL B=N
      vecs[13] = '{4'b0101, 4'b0001, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0}; // SLL B>N
      vecs[14] = '{4'b0101, 4'b1111, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1}; // SLL by 0
      vecs[15] = '{4'b0110, 4'b0110, 4'b0001, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0}; // SRL 1, out bit 0
      vecs[16] = '{4'b0110, 4'b0101, 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0}; // SRL 1, out bit 1
      vecs[17] = '{4'b0111, 4'b0110, 4'b0010, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0}; // SRA positive
      vecs[18] = '{4'b0111, 4'b0100, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0}; // SRA max amount
      vecs[19] = '{4'b1000, 4'b1010, 4'b0000, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0}; // NOT
      vecs[20] = '{4'b1001, 4'b0000, 4'b1110, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b1}; // PASS
      vecs[21] = '{4'b1010, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0}; // reserved
      vecs[22] = '{4'b1111, 4'b0111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0}; // reserved
      vecs[23] = '{4'b0001, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b0}; // SUB neg overflow
      vecs[24] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0}; // ADD neg overflow
      vecs[25] = '{4'b0001, 4'b0101, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0}; // SUB equal

      // Reset state: outputs held at zero while rst_n is low, even across edges.
      rst_n = 1'b0;
      A     = 4'b0111;
      B     = 4'b0010;
      sel   = 4'b0000;
      #2;
      check("reset_initial", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("reset_held_over_edge", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

      // Release between edges; first rising edge captures current inputs.
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("first_edge_after_reset", 4'b1001, 1'b0, 1'b1, 1'b0, 1'b1);

      // Table: new inputs every cycle, each result checked one edge later.
      for (int i = 0; i < NV; i++) begin
         sel = vecs[i].sel;
         A   = vecs[i].a;
         B   = vecs[i].b;
         @(posedge clk); #1;
         check($sformatf("vec%0d", i), vecs[i].out, vecs[i].z, vecs[i].o,
               vecs[i].ca, vecs[i].neg);
      end

      // Inputs changed mid-cycle must not disturb the registered result.
      sel = 4'b1001; A = 4'b0000; B = 4'b0110;
      @(posedge clk); #1;
      check("pass_before_change", 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
      sel = 4'b1000; A = 4'b0000;
      #3;
      check("stable_between_edges", 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("change_takes_effect", 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);

      // Async reset between edges while out is nonzero.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_reset_immediate", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      sel = 4'b0000; A = 4'b0011; B = 4'b1101;
      @(posedge clk); #1;
      check("async_reset_held", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("after_release", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
      sel = 4'b0001; A = 4'b1111; B = 4'b0110;
      @(posedge clk); #1;
      check("second_after_release", 4'b1001, 1'b0, 1'b0, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
